// File: rtl/i2c_apb_arbiter.sv
// i2c_apb_arbiter
// Round-robin arbiter plus APB master sequencer that shares the I2C
// controller's APB register port between NUM_REQ requesters. One register
// access is accepted per handshake. It is run as SETUP then ACCESS, and it
// completes with read data and an error flag. The error flag marks an access
// that was aborted because pready did not arrive within TIMEOUT_CYC cycles.
//
// Ports:
//   pclk_i, preset_i        clock, synchronous active-high reset
//   req_valid_i/req_ready_o per-requester handshake (ready only in IDLE)
//   req_write_i/addr/wdata  per-requester request fields (packed)
//   rsp_valid_o             one-cycle completion pulse to owning requester
//   rsp_rdata_o, rsp_err_o  read data / timeout flag, valid with rsp_valid_o
//   psel_o ... pready_i     APB master port
module i2c_apb_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      pclk_i,
  input  logic                      preset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e               state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;

  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(last_grant_q) + 32'd1 + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && grant_found) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    wait_cnt_d   = wait_cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          psel_d       = 1'b1;
          pwrite_d     = req_write_i[grant_idx];
          paddr_d      = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
          pwdata_d     = req_wdata_i[grant_idx*DATA_W +: DATA_W];
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        // Normal completion takes priority over a timeout on the same cycle.
        if (pready_i) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = pwrite_q ? '0 : prdata_i;
          rsp_err_d            = 1'b0;
          state_d              = IDLE;
        end else if (TIMEOUT_CYC > 0 && wait_cnt_q == CNT_LAST) begin
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          state_d              = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      wait_cnt_q   <= '0;
      last_grant_q <= LAST_RST;
      owner_q      <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      wait_cnt_q   <= wait_cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Directed bench for i2c_apb_arbiter (NUM_REQ=2, 8-bit addr/data, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_i2c_apb_arbiter;

  logic       pclk_i = 1'b0;
  logic       preset_i;
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  logic [1:0] req_write_i;
  logic [15:0] req_addr_i;
  logic [15:0] req_wdata_i;
  logic [1:0] rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       rsp_err_o;
  logic       psel_o;
  logic       penable_o;
  logic       pwrite_o;
  logic [7:0] paddr_o;
  logic [7:0] pwdata_o;
  logic [7:0] prdata_i;
  logic       pready_i;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  always #5 pclk_i = ~pclk_i;

  i2c_apb_arbiter #(
    .NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .pclk_i(pclk_i), .preset_i(preset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i)
  );

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic test_reset();
    preset_i = 1'b1; req_valid_i = '0; req_write_i = '0;
    req_addr_i = '0; req_wdata_i = '0; prdata_i = '0; pready_i = 1'b0;
    tick(); tick();
    preset_i = 1'b0;
    #1;
    vec_cnt++; if (psel_o !== 1'b0) begin err_cnt++; $display("FAIL rst_psel got=%b exp=0", psel_o); end
    vec_cnt++; if (penable_o !== 1'b0) begin err_cnt++; $display("FAIL rst_penable got=%b exp=0", penable_o); end
    vec_cnt++; if (rsp_valid_o !== 2'b00) begin err_cnt++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid_o); end
    vec_cnt++; if (rsp_rdata_o !== 8'h00) begin err_cnt++; $display("FAIL rst_rdata got=%h exp=00", rsp_rdata_o); end
    vec_cnt++; if (rsp_err_o !== 1'b0) begin err_cnt++; $display("FAIL rst_err got=%b exp=0", rsp_err_o); end
    vec_cnt++; if ({pwrite_o, paddr_o, pwdata_o} !== 17'h0) begin err_cnt++; $display("FAIL rst_apb got=%b/%h/%h exp=0/00/00", pwrite_o, paddr_o, pwdata_o); end
    vec_cnt++; if (req_ready_o !== 2'b00) begin err_cnt++; $display("FAIL rst_ready got=%b exp=00", req_ready_o); end
  endtask

  task automatic test_single_read();
    req_valid_i = 2'b01; req_write_i = 2'b00; req_addr_i = 16'h0004;
    #1;
    vec_cnt++; if (req_ready_o !== 2'b01) begin err_cnt++; $display("FAIL rd_ready got=%b exp=01", req_ready_o); end
    tick();  // t+1
    req_valid_i = '0;
    vec_cnt++; if ({psel_o, penable_o} !== 2'b10) begin err_cnt++; $display("FAIL rd_setup got=%b exp=10", {psel_o, penable_o}); end
    vec_cnt++; if ({pwrite_o, paddr_o} !== 9'h004) begin err_cnt++; $display("FAIL rd_addr got=%b/%h exp=0/04", pwrite_o, paddr_o); end
    tick();  // t+2
    vec_cnt++; if ({psel_o, penable_o} !== 2'b11) begin err_cnt++; $display("FAIL rd_access got=%b exp=11", {psel_o, penable_o}); end
    pready_i = 1'b1; prdata_i = 8'hA5;
    tick();  // t+3
    pready_i = 1'b0; prdata_i = 8'h00;
    vec_cnt++; if (rsp_valid_o !== 2'b01) begin err_cnt++; $display("FAIL rd_rsp_valid got=%b exp=01", rsp_valid_o); end
    vec_cnt++; if (rsp_rdata_o !== 8'hA5) begin err_cnt++; $display("FAIL rd_rdata got=%h exp=a5", rsp_rdata_o); end
    vec_cnt++; if (rsp_err_o !== 1'b0) begin err_cnt++; $display("FAIL rd_err got=%b exp=0", rsp_err_o); end
    vec_cnt++; if (psel_o !== 1'b0) begin err_cnt++; $display("FAIL rd_psel_end got=%b exp=0", psel_o); end
  endtask

  task automatic test_write_wait();
    req_valid_i = 2'b10; req_write_i = 2'b10;
    req_addr_i = 16'h0800; req_wdata_i = 16'h3C00;
    #1;
    vec_cnt++; if (req_ready_o !== 2'b10) begin err_cnt++; $display("FAIL wr_ready got=%b exp=10", req_ready_o); end
    tick();  // SETUP
    req_valid_i = '0; req_write_i = '0; req_addr_i = 16'hFFFF; req_wdata_i = 16'hFFFF;
    vec_cnt++; if ({pwrite_o, paddr_o, pwdata_o} !== {1'b1, 8'h08, 8'h3C}) begin err_cnt++; $display("FAIL wr_setup_fields got=%b/%h/%h exp=1/08/3c", pwrite_o, paddr_o, pwdata_o); end
    for (int i = 0; i < 4; i++) begin
      tick();  // ACCESS cycle i
      vec_cnt++;
      if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== {3'b111, 8'h08, 8'h3C}) begin
        err_cnt++; $display("FAIL wr_access%0d got=%b%b%b/%h/%h exp=111/08/3c", i, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o);
      end
      vec_cnt++; if (rsp_valid_o !== 2'b00) begin err_cnt++; $display("FAIL wr_early_rsp%0d got=%b exp=00", i, rsp_valid_o); end
      if (i == 3) begin pready_i = 1'b1; prdata_i = 8'hEE; end
    end
    tick();
    pready_i = 1'b0; prdata_i = 8'h00;
    vec_cnt++; if (rsp_valid_o !== 2'b10) begin err_cnt++; $display("FAIL wr_rsp_valid got=%b exp=10", rsp_valid_o); end
    vec_cnt++; if ({rsp_err_o, rsp_rdata_o} !== 9'h000) begin err_cnt++; $display("FAIL wr_rsp_data got=%b/%h exp=0/00", rsp_err_o, rsp_rdata_o); end
    vec_cnt++; if ({pwrite_o, paddr_o} !== {1'b1, 8'h08}) begin err_cnt++; $display("FAIL wr_hold_idle got=%b/%h exp=1/08", pwrite_o, paddr_o); end
  endtask

  // Last grant is requester 1 here, so requester 0 goes first.
  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [7:0] exp_a;
    req_valid_i = 2'b11; req_write_i = 2'b00; req_addr_i = 16'h2211;
    pready_i = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (n % 2 == 0) ? 8'h11 : 8'h22;
      prdata_i = 8'h40 + 8'(n);
      #1;
      vec_cnt++; if (req_ready_o !== exp_g) begin err_cnt++; $display("FAIL rr_grant%0d got=%b exp=%b", n, req_ready_o, exp_g); end
      tick();
      vec_cnt++; if (paddr_o !== exp_a) begin err_cnt++; $display("FAIL rr_addr%0d got=%h exp=%h", n, paddr_o, exp_a); end
      tick();
      tick();
      vec_cnt++; if (rsp_valid_o !== exp_g) begin err_cnt++; $display("FAIL rr_rsp%0d got=%b exp=%b", n, rsp_valid_o, exp_g); end
      vec_cnt++; if (rsp_rdata_o !== 8'h40 + 8'(n)) begin err_cnt++; $display("FAIL rr_rdata%0d got=%h exp=%h", n, rsp_rdata_o, 8'h40 + 8'(n)); end
    end
    req_valid_i = '0; pready_i = 1'b0; prdata_i = '0;
  endtask

  task automatic test_timeout(input logic late_ready);
    req_valid_i = 2'b01; req_write_i = 2'b00; req_addr_i = 16'h0033;
    tick();  // SETUP
    req_valid_i = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      vec_cnt++; if ({psel_o, penable_o, rsp_valid_o} !== 4'b1100) begin err_cnt++; $display("FAIL to_access%0d late=%b got=%b exp=1100", i, late_ready, {psel_o, penable_o, rsp_valid_o}); end
      if (i == 15 && late_ready) begin pready_i = 1'b1; prdata_i = 8'h5A; end
    end
    tick();
    pready_i = 1'b0; prdata_i = '0;
    vec_cnt++; if ({psel_o, penable_o} !== 2'b00) begin err_cnt++; $display("FAIL to_bus_idle late=%b got=%b exp=00", late_ready, {psel_o, penable_o}); end
    vec_cnt++; if (rsp_valid_o !== 2'b01) begin err_cnt++; $display("FAIL to_rsp late=%b got=%b exp=01", late_ready, rsp_valid_o); end
    vec_cnt++; if (rsp_err_o !== !late_ready) begin err_cnt++; $display("FAIL to_err late=%b got=%b exp=%b", late_ready, rsp_err_o, !late_ready); end
    vec_cnt++; if (rsp_rdata_o !== (late_ready ? 8'h5A : 8'h00)) begin err_cnt++; $display("FAIL to_rdata late=%b got=%h exp=%h", late_ready, rsp_rdata_o, late_ready ? 8'h5A : 8'h00); end
  endtask

  // Last grant is requester 0 going in; reset must restore requester 0 priority.
  task automatic test_reset_in_access();
    req_valid_i = 2'b01; req_write_i = 2'b00; req_addr_i = 16'h0077;
    tick();  // SETUP
    req_valid_i = '0;
    tick(); tick();  // two ACCESS cycles, no pready
    preset_i = 1'b1;
    tick();
    preset_i = 1'b0;
    vec_cnt++; if ({psel_o, penable_o, rsp_valid_o} !== 4'b0000) begin err_cnt++; $display("FAIL ra_bus got=%b exp=0000", {psel_o, penable_o, rsp_valid_o}); end
    vec_cnt++; if (rsp_rdata_o !== 8'h00) begin err_cnt++; $display("FAIL ra_rdata got=%h exp=00", rsp_rdata_o); end
    tick();
    vec_cnt++; if ({psel_o, rsp_valid_o} !== 3'b000) begin err_cnt++; $display("FAIL ra_after got=%b exp=000", {psel_o, rsp_valid_o}); end
    req_valid_i = 2'b11; req_addr_i = 16'h9988;
    #1;
    vec_cnt++; if (req_ready_o !== 2'b01) begin err_cnt++; $display("FAIL ra_first_grant got=%b exp=01", req_ready_o); end
    tick();
    req_valid_i = '0; pready_i = 1'b1; prdata_i = 8'h66;
    vec_cnt++; if (paddr_o !== 8'h88) begin err_cnt++; $display("FAIL ra_addr got=%h exp=88", paddr_o); end
    tick(); tick();
    pready_i = 1'b0;
    vec_cnt++; if (rsp_valid_o !== 2'b01) begin err_cnt++; $display("FAIL ra_rsp got=%b exp=01", rsp_valid_o); end
  endtask

  task automatic test_back_to_back();
    req_valid_i = 2'b01; req_write_i = 2'b00; req_addr_i = 16'h0010;
    pready_i = 1'b1;
    #1;
    vec_cnt++; if (req_ready_o !== 2'b01) begin err_cnt++; $display("FAIL b2b_ready0 got=%b exp=01", req_ready_o); end
    for (int n = 0; n < 3; n++) begin
      tick();
      vec_cnt++; if (rsp_valid_o !== 2'b00) begin err_cnt++; $display("FAIL b2b_gap1_%0d got=%b exp=00", n, rsp_valid_o); end
      tick();
      prdata_i = 8'h10 + 8'(n);
      vec_cnt++; if (rsp_valid_o !== 2'b00) begin err_cnt++; $display("FAIL b2b_gap2_%0d got=%b exp=00", n, rsp_valid_o); end
      tick();
      if (n == 2) req_valid_i = '0;
      #1;
      vec_cnt++; if (rsp_valid_o !== 2'b01) begin err_cnt++; $display("FAIL b2b_rsp%0d got=%b exp=01", n, rsp_valid_o); end
      vec_cnt++; if (rsp_rdata_o !== 8'h10 + 8'(n)) begin err_cnt++; $display("FAIL b2b_rdata%0d got=%h exp=%h", n, rsp_rdata_o, 8'h10 + 8'(n)); end
      if (n < 2) begin
        vec_cnt++; if (req_ready_o !== 2'b01) begin err_cnt++; $display("FAIL b2b_same_cycle%0d got=%b exp=01", n, req_ready_o); end
      end
    end
    pready_i = 1'b0;
    tick();
    vec_cnt++; if ({rsp_valid_o, psel_o} !== 3'b000) begin err_cnt++; $display("FAIL b2b_pulse_end got=%b exp=000", {rsp_valid_o, psel_o}); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_in_access();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
